// File: rtl/display_scheduler_if.sv
// Frame handshake between one matrix producer and the display scheduler.
// The producer holds valid and data steady until it sees ready.
interface display_scheduler_if;
   logic        valid;
   logic [31:0] data;
   logic        ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/display_scheduler.sv
// Round-robin sharing of the 4-digit display between two 2x2-matrix producers:
// grant one frame, show its four bytes for DWELL_CYCLES each, then blank for GAP_CYCLES.
module display_scheduler #(
   parameter int DWELL_CYCLES = 100000000,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                 clock_100Mhz,
   input  logic                 reset,
   display_scheduler_if.slave   req0_i,
   display_scheduler_if.slave   req1_i,
   input  logic                 hold_i,
   output logic [7:0]           disp_value_o,
   output logic [1:0]           disp_idx_o,
   output logic                 disp_src_o,
   output logic                 disp_active_o,
   output logic                 frame_done_o,
   output logic                 busy_o
);

   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
   localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
   localparam logic [GW-1:0] GAP_ONE    = GW'(1);

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   state_t        state_q;
   logic [31:0]   frame_q;
   logic [1:0]    idx_q;
   logic          src_q;
   logic          last_src_q;
   logic          active_q;
   logic          done_q;
   logic          busy_q;
   logic [DW-1:0] dwell_q;
   logic [GW-1:0] gap_q;

   logic          grant0;
   logic          grant1;
   logic          can_accept;
   logic [7:0]    value_mux;

   // Ties go to the requester that was not served last; ready is masked in reset.
   always_comb begin
      grant0     = req0_i.valid & (~req1_i.valid | last_src_q);
      grant1     = req1_i.valid & (~req0_i.valid | ~last_src_q);
      can_accept = (state_q == IDLE) & ~reset;
      case (idx_q)
         2'd0:    value_mux = frame_q[31:24];
         2'd1:    value_mux = frame_q[23:16];
         2'd2:    value_mux = frame_q[15:8];
         default: value_mux = frame_q[7:0];
      endcase
   end

   assign req0_i.ready  = grant0 & can_accept;
   assign req1_i.ready  = grant1 & can_accept;
   assign disp_value_o  = value_mux;
   assign disp_idx_o    = idx_q;
   assign disp_src_o    = src_q;
   assign disp_active_o = active_q;
   assign frame_done_o  = done_q;
   assign busy_o        = busy_q;

   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         frame_q    <= '0;
         idx_q      <= '0;
         src_q      <= 1'b0;
         last_src_q <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         dwell_q    <= '0;
         gap_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant0 | grant1) begin
                  frame_q    <= grant1 ? req1_i.data : req0_i.data;
                  src_q      <= grant1;
                  last_src_q <= grant1;
                  idx_q      <= 2'd0;
                  dwell_q    <= '0;
                  active_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= SHOW;
               end
            end
            SHOW: begin
               if (!hold_i) begin
                  if (dwell_q == DWELL_LAST) begin
                     dwell_q <= '0;
                     if (idx_q != 2'd3) begin
                        idx_q <= idx_q + 2'd1;
                     end else begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        gap_q    <= '0;
                        state_q  <= GAP;
                     end
                  end else begin
                     dwell_q <= dwell_q + DWELL_ONE;
                  end
               end
            end
            GAP: begin
               // Value, index and source stay frozen on the last element while blanked.
               if (gap_q == GAP_LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q + GAP_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_display_scheduler.sv
// Randomised bench for display_scheduler with a frame-level reference model and a
// scoreboard queue of expected frames consumed by an independent output monitor.
module tb_display_scheduler;

   localparam int D    = 4;
   localparam int G    = 2;
   localparam int NCYC = 8192;

   typedef struct {
      bit          src;
      logic [31:0] data;
      int          acc;
      int          fin;
   } frame_t;

   typedef struct {
      bit src;
      int cyc;
   } acc_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic hold;
   logic [7:0] disp_value;
   logic [1:0] disp_idx;
   logic disp_src, disp_active, frame_done, busy;

   display_scheduler_if req0 ();
   display_scheduler_if req1 ();

   display_scheduler #(.DWELL_CYCLES(D), .GAP_CYCLES(G)) dut (
      .clock_100Mhz (clk),
      .reset        (rst),
      .req0_i       (req0),
      .req1_i       (req1),
      .hold_i       (hold),
      .disp_value_o (disp_value),
      .disp_idx_o   (disp_idx),
      .disp_src_o   (disp_src),
      .disp_active_o(disp_active),
      .frame_done_o (frame_done),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   bit          hold_sched [NCYC];
   frame_t      sb_q[$];
   bit          m_last = 1'b1;
   int          m_free = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   acc_t        acc_log[$];
   int          done_log[$];
   bit          dist_en = 1'b0;
   bit          clean0 = 1'b1;
   bit          clean1 = 1'b1;

   // Last SHOW cycle of a frame accepted at acc: the cycle in which the 4*D-th un-held cycle falls.
   function automatic int show_end(input int acc);
      int t = acc + 1;
      int n = 0;
      while (n < 4 * D && t < NCYC) begin
         if (!hold_sched[t]) n++;
         t++;
      end
      return t - 1;
   endfunction

   // Reference model: predicts grants and readies, pushes expected frames.
   always @(negedge clk) begin
      bit g0;
      bit g1;
      frame_t f;
      g0 = 1'b0;
      g1 = 1'b0;
      if (rst) begin
         sb_q.delete();
         m_last = 1'b1;
         m_free = 0;
         chk("ready0_in_reset", {31'd0, req0.ready}, 32'd0);
         chk("ready1_in_reset", {31'd0, req1.ready}, 32'd0);
      end else begin
         if (cyc >= m_free) begin
            g0 = req0.valid && (!req1.valid || m_last);
            g1 = req1.valid && (!req0.valid || !m_last);
         end
         chk("req0_ready", {31'd0, req0.ready}, {31'd0, g0});
         chk("req1_ready", {31'd0, req1.ready}, {31'd0, g1});
         if (g0 || g1) begin
            f.src  = g1;
            f.data = g1 ? req1.data : req0.data;
            f.acc  = cyc;
            f.fin  = show_end(cyc);
            sb_q.push_back(f);
            m_last = g1;
            m_free = f.fin + G + 1;
         end
      end
   end

   // Monitor: takes each expected frame off the scoreboard when it is due on the display.
   frame_t cur;
   bit     have_cur = 1'b0;
   always @(negedge clk) begin
      int n;
      int idx;
      logic [7:0] ev;
      if (rst) begin
         have_cur = 1'b0;
         chk("outputs_in_reset", {18'd0, disp_value, disp_idx, disp_src, disp_active, frame_done, busy}, 32'd0);
      end else begin
         if (have_cur && cyc > cur.fin + G) have_cur = 1'b0;
         if (!have_cur && sb_q.size() > 0 && sb_q[0].acc + 1 == cyc) begin
            cur = sb_q.pop_front();
            have_cur = 1'b1;
         end
         if (!have_cur) begin
            chk("idle_active", {31'd0, disp_active}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_done", {31'd0, frame_done}, 32'd0);
         end else if (cyc <= cur.fin) begin
            n = 0;
            for (int t = cur.acc + 1; t < cyc; t++) if (!hold_sched[t]) n++;
            idx = n / D;
            ev = cur.data[31 - 8 * idx -: 8];
            chk("show_active", {31'd0, disp_active}, 32'd1);
            chk("show_busy", {31'd0, busy}, 32'd1);
            chk("show_done", {31'd0, frame_done}, 32'd0);
            chk("show_idx", {30'd0, disp_idx}, idx);
            chk("show_src", {31'd0, disp_src}, {31'd0, cur.src});
            chk("show_value", {24'd0, disp_value}, {24'd0, ev});
         end else begin
            chk("gap_active", {31'd0, disp_active}, 32'd0);
            chk("gap_busy", {31'd0, busy}, 32'd1);
            chk("gap_done", {31'd0, frame_done}, {31'd0, (cyc == cur.fin + 1)});
            chk("gap_idx", {30'd0, disp_idx}, 32'd3);
            chk("gap_src", {31'd0, disp_src}, {31'd0, cur.src});
            chk("gap_value", {24'd0, disp_value}, {24'd0, cur.data[7:0]});
         end
      end
   end

   always @(negedge clk) if (!rst && frame_done) done_log.push_back(cyc);

   // Producers: one cycle per call; pop a frame only after a clean handshake.
   task automatic step();
      bit a0;
      bit a1;
      acc_t e;
      @(negedge clk);
      a0 = req0.valid && req0.ready && clean0;
      a1 = req1.valid && req1.ready && clean1;
      if (a0 || a1) begin
         e.src = a1;
         e.cyc = cyc;
         acc_log.push_back(e);
      end
      @(posedge clk);
      #1;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      hold = hold_sched[cyc];
      if (dist_en && cyc < m_free) begin
         req0.valid = 1'($urandom_range(0, 1));
         req0.data  = $urandom;
         req1.valid = 1'($urandom_range(0, 1));
         req1.data  = $urandom;
         clean0 = 1'b0;
         clean1 = 1'b0;
      end else begin
         req0.valid = (q0.size() > 0);
         req0.data  = (q0.size() > 0) ? q0[0] : $urandom;
         req1.valid = (q1.size() > 0);
         req1.data  = (q1.size() > 0) ? q1[0] : $urandom;
         clean0 = 1'b1;
         clean1 = 1'b1;
      end
   endtask

   task automatic run_until_idle(input int max_cyc);
      int k = 0;
      while ((q0.size() != 0 || q1.size() != 0 || cyc < m_free) && k < max_cyc) begin
         step();
         k++;
      end
      chk("idle_reached", {31'd0, (q0.size() == 0 && q1.size() == 0 && cyc >= m_free)}, 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      #(20000 * 10);
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int k;
      hold = 1'b0;
      req0.valid = 1'b0;
      req0.data  = '0;
      req1.valid = 1'b0;
      req1.data  = '0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Single frame then a second req0 frame back-to-back.
      acc_log.delete();
      q0.push_back(32'h0A141E28);
      q0.push_back(32'h11223344);
      run_until_idle(200);
      chk("single_accepts", acc_log.size(), 32'd2);
      if (acc_log.size() == 2) begin
         chk("single_src", {31'd0, acc_log[0].src}, 32'd0);
         chk("single_spacing", acc_log[1].cyc - acc_log[0].cyc, 4 * D + G + 1);
      end

      // Both valid from reset: alternation 0,1,0,1.
      do_reset();
      acc_log.delete();
      q0.push_back(32'h01020304);
      q0.push_back(32'h0A0B0C0D);
      q1.push_back(32'h05060708);
      q1.push_back(32'h0E0F1011);
      run_until_idle(300);
      chk("rr_accepts", acc_log.size(), 32'd4);
      for (int i = 0; i < acc_log.size() && i < 4; i++)
         chk("rr_order", {31'd0, acc_log[i].src}, i % 2);

      // Only req1, repeatedly.
      acc_log.delete();
      for (int i = 0; i < 3; i++) q1.push_back($urandom);
      run_until_idle(300);
      chk("req1_accepts", acc_log.size(), 32'd3);
      for (int i = 1; i < acc_log.size(); i++) begin
         chk("req1_spacing", acc_log[i].cyc - acc_log[i-1].cyc, 4 * D + G + 1);
         chk("req1_src", {31'd0, acc_log[i].src}, 32'd1);
      end

      // Three hold cycles inside element 1.
      acc_log.delete();
      done_log.delete();
      a = cyc + 1;
      for (int i = 0; i < 3; i++) hold_sched[a + D + 2 + i] = 1'b1;
      q0.push_back(32'hC0FFEE42);
      run_until_idle(200);
      chk("hold_accepts", acc_log.size(), 32'd1);
      chk("hold_done_count", done_log.size(), 32'd1);
      if (acc_log.size() == 1 && done_log.size() == 1)
         chk("hold_done_cycle", done_log[0], acc_log[0].cyc + 4 * D + 1 + 3);

      // Input disturbance while busy.
      dist_en = 1'b1;
      q0.push_back(32'hA1B2C3D4);
      q0.push_back(32'h55AA55AA);
      q1.push_back(32'h99887766);
      run_until_idle(400);
      dist_en = 1'b0;

      // Reset during element 2 with a req1 frame pending.
      acc_log.delete();
      q0.push_back(32'hDEADBEEF);
      k = 0;
      while (q0.size() > 0 && k < 100) begin step(); k++; end
      chk("rst_first_accept", acc_log.size(), 32'd1);
      a = (acc_log.size() > 0) ? acc_log[acc_log.size()-1].cyc : cyc;
      q1.push_back(32'h2B3C4D5E);
      k = 0;
      while (cyc < a + 2 * D + 2 && k < 100) begin step(); k++; end
      #1 rst = 1'b1;
      #1;
      chk("rst_immediate", {20'd0, disp_value, disp_idx, disp_src, disp_active, frame_done, busy, req0.ready, req1.ready}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      run_until_idle(200);
      chk("rst_resume_src", {31'd0, acc_log[acc_log.size()-1].src}, 32'd1);
      chk("rst_resume_count", acc_log.size(), 32'd2);

      // Random traffic with random hold and disturbance.
      for (int t = cyc + 2; t < cyc + 2500 && t < NCYC; t++) hold_sched[t] = ($urandom_range(0, 4) == 0);
      dist_en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 1) q0.push_back($urandom);
         else q1.push_back($urandom);
         repeat ($urandom_range(0, 30)) step();
      end
      run_until_idle(3000);
      dist_en = 1'b0;

      repeat (3) step();
      chk("scoreboard_drained", sb_q.size() + int'(have_cur), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Sequencer and arbiter that shares the single 4-digit seven-segment display path between two producers of 2x2 matrices of 8-bit values. The result producer and the input-echo producer each offer a frame of four values. The block grants one frame at a time using round-robin, captures it, and presents the four values one after another, each for a programmable dwell time. A blanking gap separates frames, and each frame ends with a done pulse. It sits between the compute datapath and the digit-scan/decoder stage, which consumes `disp_value` while `disp_active` is high.

## Interface
- `DWELL_CYCLES`, default 100000000: clock cycles each value is displayed; must be ≥1. 100000000 is 1 s at 100 MHz.
- `GAP_CYCLES`, default 2: blank cycles after each frame; must be ≥1.
- `clock_100Mhz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `req0_valid`  in  1  requester 0 (result matrix) has a frame.
- `req0_data`  in  32  frame: [31:24]=c11, [23:16]=c12, [15:8]=c21, [7:0]=c22.
- `req0_ready`  out  1  frame accepted on this edge if `req0_valid` is also high.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1 (input echo).
- `hold`  in  1  freezes the dwell countdown while high.
- `disp_value`  out  8  value currently shown.
- `disp_idx`  out  2  element index: 0=c11, 1=c12, 2=c21, 3=c22.
- `disp_src`  out  1  requester whose frame is shown.
- `disp_active`  out  1  display enable; low means blank.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SHOW, GAP.
- **Reset values:** state IDLE, all outputs 0, `last_src`=1 (so requester 0 wins the first tie). Frame buffer and dwell counter are cleared.
- **IDLE, arbitration:**
  - Arbitration and ready are combinational from the valid inputs.
  - If only one requester is valid, it is granted.
  - If both are valid, the one ≠ `last_src` is granted.
  - The granted requester's ready is high. At most one ready is high in any cycle.
  - Both readies are 0 outside IDLE.
- **Accept** (granted valid & ready at a clock edge):
  - Capture the 32-bit data; `disp_src` ← granted index; `last_src` ← granted index.
  - `disp_idx` ← 0; dwell counter ← 0; state → SHOW.
- **SHOW:**
  - `disp_active`=1.
  - `disp_value` = captured byte selected by `disp_idx`: idx 0 → [31:24], idx 3 → [7:0].
  - Dwell counter increments each cycle unless `hold`=1.
  - When the counter equals `DWELL_CYCLES`-1 and `hold`=0:
    - Counter ← 0.
    - If `disp_idx`<3, `disp_idx` increments.
    - Otherwise state → GAP, `frame_done` ← 1 (registered, high for the first GAP cycle only), gap counter ← 0.
- **GAP:**
  - `disp_active`=0; `disp_value`, `disp_idx` and `disp_src` hold their last values.
  - After `GAP_CYCLES` cycles, state → IDLE.
  - `hold` has no effect in GAP.
- **Counter widths:** sized by `$clog2` of each parameter. Counters never wrap mid-dwell; `disp_idx` never wraps past 3.
- **Changing inputs:** input data or valid changes while busy have no effect. A requester must keep valid high until it sees ready, and its data must stay stable while valid is high.
- **Reset mid-frame:** the frame is discarded and all outputs go to reset values at once. The frame is not resumed after reset releases.

## Timing
- Accept edge = end of cycle T.
- SHOW lasts cycles T+1 to T+4·`DWELL_CYCLES`. Element k is shown in cycles T+1+k·D to T+(k+1)·D, where D=`DWELL_CYCLES`, with no hold applied.
- `frame_done` high in cycle T+4D+1.
- GAP lasts cycles T+4D+1 to T+4D+`GAP_CYCLES`.
- IDLE in cycle T+4D+`GAP_CYCLES`+1; ready can go high that cycle and the next frame can be accepted then.
- Each cycle with `hold`=1 in SHOW extends the timeline by one cycle.
- Throughput: one frame per 4D+`GAP_CYCLES`+1 cycles, at most.

## Test plan
All scenarios use `DWELL_CYCLES`=4 and `GAP_CYCLES`=2.
- **Single frame:** `req0_data`=0x0A141E28 accepted at T → `disp_value` is 10,20,30,40 for 4 cycles each in T+1 to T+16; `disp_src`=0; `frame_done` high only at T+17; `disp_active`=0 in T+17 to T+18; `req0_ready`=1 at T+19.
- **Both valid from reset:** req0 = 0x01020304, req1 = 0x05060708, both valid → req0 is served first and req1 second (`disp_src`=1, values 5,6,7,8). With both held valid, the service order keeps alternating 0,1,0,1.
- **Only req1 valid repeatedly:** req1 is served back-to-back; each accept occurs exactly 19 cycles after the previous one; `req0_ready` stays 0.
- **Hold:** `hold`=1 for 3 cycles during element 1 → element 1 is shown for 7 cycles; `frame_done` moves 3 cycles later.
- **Input disturbance while busy:** change `req0_data` and toggle `req1_valid` during SHOW → displayed values are unchanged; both readies stay 0 until IDLE.
- **Reset mid-frame:** assert reset during element 2 → outputs are 0 and `busy`=0 immediately. After release, a pending req1 frame is shown from idx 0 (`last_src` was reset to 1, but req1 is the only valid requester, so it is granted).
